// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calc_* result-collection blocks.
//   - calc_acc_state_t : control states of calc_result_accum
//   - CALC_DATA_W      : width of the upstream thresholded-adder results
//   - default frame length and accumulator width
// ---------------------------------------------------------------------------
package calc_pkg;

    localparam int CALC_DATA_W        = 32;
    localparam int CALC_FRAME_LEN_DEF = 8;
    localparam int CALC_ACC_W_DEF     = 40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } calc_acc_state_t;

endpackage

// File: rtl/calc_result_accum_if.sv
// ---------------------------------------------------------------------------
// calc_result_accum_if
// Bundles the block-level handshake, the upstream result stream and the
// frame-summary output of calc_result_accum.
//   Parameters: ACC_W (frame-sum width), CNT_W (hit-count width)
//   slave  modport : the collector block
//   master modport : whoever drives start/results and consumes the summary
// Optional signal max_out exists only when CALC_ACCUM_MAX_EN is defined.
// ---------------------------------------------------------------------------
interface calc_result_accum_if
    import calc_pkg::*;
#(
    parameter int ACC_W = CALC_ACC_W_DEF,
    parameter int CNT_W = 4
);

    logic                   ap_start;
    logic                   ap_ready;
    logic                   ap_idle;
    logic                   ap_done;
    logic [CALC_DATA_W-1:0] res_data;
    logic                   res_valid;
    logic                   res_ready;
    logic [ACC_W-1:0]       sum_out;
    logic [CNT_W-1:0]       hit_count;
    logic                   out_valid;
    logic                   out_ready;
`ifdef CALC_ACCUM_MAX_EN
    logic [CALC_DATA_W-1:0] max_out;
`endif

    modport slave (
`ifdef CALC_ACCUM_MAX_EN
        output max_out,
`endif
        input  ap_start,
        output ap_ready,
        output ap_idle,
        output ap_done,
        input  res_data,
        input  res_valid,
        output res_ready,
        output sum_out,
        output hit_count,
        output out_valid,
        input  out_ready
    );

    modport master (
`ifdef CALC_ACCUM_MAX_EN
        input  max_out,
`endif
        output ap_start,
        input  ap_ready,
        input  ap_idle,
        input  ap_done,
        output res_data,
        output res_valid,
        input  res_ready,
        input  sum_out,
        input  hit_count,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/calc_sat_acc.sv
// ---------------------------------------------------------------------------
// calc_sat_acc
// ACC_W-wide unsigned accumulator that saturates at 2^ACC_W-1.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : load zero (takes priority over en)
//   en         : add din (zero-extended) into the accumulator
//   din        : 32-bit unsigned addend
//   sum_next   : saturated value acc + din, i.e. what the accumulator holds
//                after an enabled cycle
// ---------------------------------------------------------------------------
module calc_sat_acc
    import calc_pkg::*;
#(
    parameter int ACC_W = CALC_ACC_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   en,
    input  logic [CALC_DATA_W-1:0] din,
    output logic [ACC_W-1:0]       sum_next
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    // One extra bit catches the carry; a carry clamps to all-ones. Since
    // addends are never negative, a saturated value stays saturated.
    function automatic logic [ACC_W-1:0] sat_add(
        input logic [ACC_W-1:0]       a,
        input logic [CALC_DATA_W-1:0] b
    );
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W + 1 - CALC_DATA_W){1'b0}}, b};
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    assign sum_next = sat_add(acc_q, din);

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/calc_result_accum.sv
// ---------------------------------------------------------------------------
// calc_result_accum
// Collects FRAME_LEN results from the thresholded-adder stage, producing a
// saturated frame sum and a count of nonzero results, then holds the summary
// until downstream takes it.
//   ap_clk   : clock (rising edge)
//   ap_rst_n : asynchronous active-low reset
//   bus      : calc_result_accum_if.slave
//                ap_start/ap_ready/ap_idle/ap_done  block handshake
//                res_data/res_valid/res_ready       input result stream
//                sum_out/hit_count/out_valid/out_ready  frame summary
// Optional feature macro: CALC_ACCUM_MAX_EN adds the per-frame maximum on
// bus.max_out.
// ---------------------------------------------------------------------------
module calc_result_accum
    import calc_pkg::*;
#(
    parameter int FRAME_LEN = CALC_FRAME_LEN_DEF,
    parameter int ACC_W     = CALC_ACC_W_DEF,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    calc_result_accum_if.slave    bus
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    calc_acc_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hits_q, hits_d;
    logic [ACC_W-1:0] sum_out_q, sum_out_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic             ap_ready_q, ap_ready_d;
    logic             ap_done_q, ap_done_d;

    logic             acc_clr;
    logic             acc_en;
    logic [ACC_W-1:0] acc_sum_next;
    logic [CNT_W-1:0] hits_next;
    logic             beat;

`ifdef CALC_ACCUM_MAX_EN
    logic [CALC_DATA_W-1:0] max_q, max_d;
    logic [CALC_DATA_W-1:0] max_out_q, max_out_d;
    logic [CALC_DATA_W-1:0] max_next;

    assign max_next = (bus.res_data > max_q) ? bus.res_data : max_q;
`endif

    calc_sat_acc #(
        .ACC_W (ACC_W)
    ) u_sat_acc (
        .clk      (ap_clk),
        .rst_n    (ap_rst_n),
        .clr      (acc_clr),
        .en       (acc_en),
        .din      (bus.res_data),
        .sum_next (acc_sum_next)
    );

    // res_ready is a pure state decode, so a beat needs only res_valid here.
    assign beat      = (state_q == ACCUM) && bus.res_valid;
    assign hits_next = hits_q + CNT_W'(bus.res_data != '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hits_d      = hits_q;
        sum_out_d   = sum_out_q;
        hit_count_d = hit_count_q;
        ap_ready_d  = 1'b0;
        ap_done_d   = 1'b0;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;
`ifdef CALC_ACCUM_MAX_EN
        max_d       = max_q;
        max_out_d   = max_out_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.ap_start) begin
                    ap_ready_d = 1'b1;
                    acc_clr    = 1'b1;
                    cnt_d      = '0;
                    hits_d     = '0;
`ifdef CALC_ACCUM_MAX_EN
                    max_d      = '0;
`endif
                    state_d    = ACCUM;
                end
            end

            ACCUM: begin
                if (beat) begin
                    acc_en = 1'b1;
                    hits_d = hits_next;
                    cnt_d  = cnt_q + CNT_W'(1);
`ifdef CALC_ACCUM_MAX_EN
                    max_d  = max_next;
`endif
                    // Summary is taken from the post-beat values so the
                    // final result lands in the same edge as the last beat.
                    if (cnt_q == LAST_IDX) begin
                        sum_out_d   = acc_sum_next;
                        hit_count_d = hits_next;
`ifdef CALC_ACCUM_MAX_EN
                        max_out_d   = max_next;
`endif
                        state_d     = HOLD;
                    end
                end
            end

            HOLD: begin
                if (bus.out_ready) begin
                    ap_done_d = 1'b1;
                    if (bus.ap_start) begin
                        ap_ready_d = 1'b1;
                        acc_clr    = 1'b1;
                        cnt_d      = '0;
                        hits_d     = '0;
`ifdef CALC_ACCUM_MAX_EN
                        max_d      = '0;
`endif
                        state_d    = ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hits_q      <= '0;
            sum_out_q   <= '0;
            hit_count_q <= '0;
            ap_ready_q  <= 1'b0;
            ap_done_q   <= 1'b0;
`ifdef CALC_ACCUM_MAX_EN
            max_q       <= '0;
            max_out_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hits_q      <= hits_d;
            sum_out_q   <= sum_out_d;
            hit_count_q <= hit_count_d;
            ap_ready_q  <= ap_ready_d;
            ap_done_q   <= ap_done_d;
`ifdef CALC_ACCUM_MAX_EN
            max_q       <= max_d;
            max_out_q   <= max_out_d;
`endif
        end
    end

    assign bus.ap_ready  = ap_ready_q;
    assign bus.ap_done   = ap_done_q;
    assign bus.ap_idle   = (state_q == IDLE);
    assign bus.res_ready = (state_q == ACCUM);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.sum_out   = sum_out_q;
    assign bus.hit_count = hit_count_q;
`ifdef CALC_ACCUM_MAX_EN
    assign bus.max_out   = max_out_q;
`endif

endmodule
